// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: APB3/APB4 bus between the command master and a register slave
interface apb_cmd_master_if #(
    parameter int APB_ADDR_WIDTH  = 32,
    parameter int APB_DATA_WIDTH  = 32,
    parameter int APB_PPROT_WIDTH = 3,
    parameter int APB_PSTRB_WIDTH = 4
);
    logic [APB_ADDR_WIDTH-1:0]  paddr;
    logic                       psel;
    logic                       penable;
    logic                       pwrite;
    logic [APB_DATA_WIDTH-1:0]  pwdata;
    logic [APB_PSTRB_WIDTH-1:0] pstrb;
    logic [APB_PPROT_WIDTH-1:0] pprot;
    logic [APB_DATA_WIDTH-1:0]  prdata;
    logic                       pready;
    logic                       pslverr;
    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  prdata, pready, pslverr
    );
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns one valid/ready command into one APB transfer and returns a response with PREADY timeout
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH  = 32,
    parameter int APB_DATA_WIDTH  = 32,
    parameter int APB_PPROT_WIDTH = 3,
    parameter int APB_PSTRB_WIDTH = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0]  cmd_wdata,
    input  logic [APB_PSTRB_WIDTH-1:0] cmd_strb,
    input  logic [APB_PPROT_WIDTH-1:0] cmd_prot,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [APB_DATA_WIDTH-1:0]  rsp_rdata,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic                       busy,
    apb_cmd_master_if.master           m_apb
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_d;
    logic [TW-1:0] cnt;
    logic accept, done, expire, psel_d, penable_d, rsp_valid_d;
    assign cmd_ready = state == IDLE;
    assign busy = state != IDLE;
    assign accept = cmd_valid & cmd_ready;
    assign done = state == ACCESS & m_apb.pready;
    // pready has priority over the timeout terminal count
    assign expire = state == ACCESS & ~m_apb.pready & (TIMEOUT_CYCLES != 0) & cnt == LAST;
    always_comb begin
        state_d = accept ? SETUP :
                  state == SETUP ? ACCESS :
                  (done | expire) ? RESP :
                  (state == RESP & rsp_ready) ? IDLE : state;
    end
    // outputs are registered, so they are derived from the state being entered
    always_comb begin
        psel_d = state_d == SETUP || state_d == ACCESS;
        penable_d = state_d == ACCESS;
        rsp_valid_d = state_d == RESP;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            m_apb.psel <= 1'b0;
            m_apb.penable <= 1'b0;
            m_apb.paddr <= '0;
            m_apb.pwrite <= 1'b0;
            m_apb.pwdata <= '0;
            m_apb.pstrb <= '0;
            m_apb.pprot <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= state == ACCESS ? cnt + 1'b1 : '0;
            m_apb.psel <= psel_d;
            m_apb.penable <= penable_d;
            rsp_valid <= rsp_valid_d;
            if (accept) begin
                m_apb.paddr <= cmd_addr;
                m_apb.pwrite <= cmd_write;
                m_apb.pwdata <= cmd_wdata;
                m_apb.pstrb <= cmd_write ? cmd_strb : '0;
                m_apb.pprot <= cmd_prot;
            end
            if (done | expire) begin
                rsp_rdata <= (done & ~m_apb.pwrite) ? m_apb.prdata : '0;
                rsp_err <= done ? m_apb.pslverr : 1'b1;
                rsp_timeout <= ~done;
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench with a bus-level reference model checked every cycle
module tb_apb_cmd_master;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, rsp_rdata;
    logic [3:0] cmd_strb = '0;
    logic [2:0] cmd_prot = '0;
    int tests = 0, fails = 0;
    apb_cmd_master_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .APB_PPROT_WIDTH(3), .APB_PSTRB_WIDTH(4)) bus ();
    apb_cmd_master #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .APB_PPROT_WIDTH(3), .APB_PSTRB_WIDTH(4),
                     .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy), .m_apb(bus)
    );
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // reference model: tracks the bus by its observable phases, not by the RTL encoding
    logic m_busy, m_psel, m_pen, m_rv, m_write, m_err, m_to;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0] m_strb;
    logic [2:0] m_prot;
    int m_acc;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 0; m_psel <= 0; m_pen <= 0; m_rv <= 0; m_write <= 0; m_err <= 0; m_to <= 0;
            m_addr <= 0; m_wdata <= 0; m_rdata <= 0; m_strb <= 0; m_prot <= 0; m_acc <= 0;
        end else if (m_rv) begin
            if (rsp_ready) begin
                m_rv <= 0;
                m_busy <= 0;
            end
        end else if (m_pen) begin
            m_acc <= m_acc + 1;
            if (bus.pready || m_acc + 1 == TO) begin
                m_psel <= 0;
                m_pen <= 0;
                m_rv <= 1;
                m_rdata <= (bus.pready && !m_write) ? bus.prdata : 32'h0;
                m_err <= bus.pready ? bus.pslverr : 1'b1;
                m_to <= !bus.pready;
            end
        end else if (m_psel) begin
            m_pen <= 1;
        end else if (cmd_valid && !m_busy) begin
            m_busy <= 1; m_psel <= 1; m_acc <= 0;
            m_write <= cmd_write; m_addr <= cmd_addr; m_wdata <= cmd_wdata; m_prot <= cmd_prot;
            m_strb <= cmd_write ? cmd_strb : 4'h0;
        end
    end
    always @(negedge clk) begin
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("psel", bus.psel, m_psel);
        chk("penable", bus.penable, m_pen);
        chk("rsp_valid", rsp_valid, m_rv);
        if (m_psel) begin
            chk("paddr", bus.paddr, m_addr);
            chk("pwrite", bus.pwrite, m_write);
            chk("pwdata", bus.pwdata, m_wdata);
            chk("pstrb", bus.pstrb, m_strb);
            chk("pprot", bus.pprot, m_prot);
        end
        if (m_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
    end
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    // returns in the SETUP cycle of the accepted command
    task automatic send(logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s, logic [2:0] p);
        int g = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        while (!cmd_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int n;
        bus.pready = 1; bus.prdata = 32'h5A5A5A5A; bus.pslverr = 0;
        #13;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_psel", bus.psel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        tick(); tick();
        reset = 1;
        tick();
        // zero-wait write
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h2);
        chk("w_setup_psel", bus.psel, 1);
        chk("w_setup_pen", bus.penable, 0);
        tick();
        chk("w_access_pen", bus.penable, 1);
        chk("w_paddr", bus.paddr, 32'h10);
        chk("w_pstrb", bus.pstrb, 4'hF);
        tick();
        chk("w_rsp_valid", rsp_valid, 1);
        chk("w_rsp_err", rsp_err, 0);
        chk("w_rsp_rdata", rsp_rdata, 0);
        tick();
        // read with three wait states
        bus.pready = 0;
        send(0, 32'h20, 32'h11111111, 4'hF, 3'h0);
        chk("r_pstrb", bus.pstrb, 0);
        tick(); tick(); tick(); tick();
        bus.pready = 1; bus.prdata = 32'h12345678;
        tick();
        bus.pready = 0; bus.prdata = 32'hFFFF0000;
        chk("r_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("r_rsp_err", rsp_err, 0);
        tick();
        // slave error
        bus.pready = 1; bus.pslverr = 1;
        send(0, 32'h40, 32'h0, 4'h0, 3'h1);
        tick(); tick();
        bus.pslverr = 0;
        chk("e_rsp_err", rsp_err, 1);
        chk("e_rsp_timeout", rsp_timeout, 0);
        tick();
        // timeout
        bus.pready = 0; bus.prdata = 32'hAAAA5555;
        send(0, 32'h80, 32'h0, 4'h0, 3'h0);
        tick();
        n = 0;
        while (bus.penable && n < 20) begin
            n++;
            tick();
        end
        chk("t_access_cycles", n, TO);
        chk("t_psel", bus.psel, 0);
        chk("t_rsp_err", rsp_err, 1);
        chk("t_rsp_timeout", rsp_timeout, 1);
        chk("t_rsp_rdata", rsp_rdata, 0);
        tick();
        // response backpressure with a queued second command
        bus.pready = 1; bus.prdata = 32'hCAFEF00D; rsp_ready = 0;
        send(0, 32'h44, 32'h0, 4'h0, 3'h0);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h48; cmd_wdata = 32'h01020304; cmd_strb = 4'h3;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
            if (i == 4) rsp_ready = 1;
            tick();
        end
        chk("bp_ready_after", cmd_ready, 1);
        chk("bp_psel_idle", bus.psel, 0);
        tick();
        cmd_valid = 0;
        chk("bp_second_psel", bus.psel, 1);
        chk("bp_second_addr", bus.paddr, 32'h48);
        tick(); tick(); tick();
        // reset during a wait-state ACCESS
        bus.pready = 0;
        send(0, 32'h50, 32'h0, 4'h0, 3'h0);
        tick(); tick();
        chk("rm_pen_before", bus.penable, 1);
        #1 reset = 0;
        #1;
        chk("rm_psel", bus.psel, 0);
        chk("rm_pen", bus.penable, 0);
        chk("rm_rsp_valid", rsp_valid, 0);
        chk("rm_cmd_ready", cmd_ready, 1);
        tick();
        reset = 1;
        bus.pready = 1; bus.prdata = 32'h0BADCAFE;
        tick();
        send(0, 32'h60, 32'h0, 4'h0, 3'h0);
        tick(); tick();
        chk("rm_new_rdata", rsp_rdata, 32'h0BADCAFE);
        chk("rm_new_valid", rsp_valid, 1);
        tick(); tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
